// File: rtl/pixy_reset_pkg.sv
// Shared definitions for the 68000 reset/halt monitor.
// Holds the FSM state encoding and the default timing constants.
package pixy_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RUN = 3'd0,
        ST_IDLE     = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_STRETCH  = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    localparam int unsigned DEF_MIN_PULSE = 16;
    localparam int unsigned DEF_STRETCH   = 64;
    localparam int unsigned DEF_HALT_MIN  = 256;

endpackage

// File: rtl/cpu_reset_monitor_line_sync.sv
// Multi-stage synchronizer for one asynchronous pin; i_d is already active-high.
// The flops clear to 0 (not asserted) on RESET_ALL_IN.
module line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic MCLK_IN,
    input  logic RESET_ALL_IN,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // NOTE: clocked state uses non-blocking assignments so each stage takes the pre-edge value of the one before.
    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_reset_monitor.sv
// Decodes CPU-driven RESET (RESET instruction) and HALT events into a stretched peripheral reset and a halt flag.
// Optional saturating event counter on RESET_EVENTS when CPU_RESET_MONITOR_COUNT_EN is defined.
module cpu_reset_monitor
    import pixy_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PULSE   = DEF_MIN_PULSE,
    parameter int unsigned STRETCH     = DEF_STRETCH,
    parameter int unsigned HALT_MIN    = DEF_HALT_MIN
) (
    input  logic       MCLK_IN,
    input  logic       RESET_ALL_IN,
    input  logic       RUN_IN,
    input  logic       CPU_RESET_N_IN,
    input  logic       CPU_HALT_N_IN,
    output logic       PERIPH_RESET,
    output logic       RESET_SEEN,
    output logic       CPU_HALTED
`ifdef CPU_RESET_MONITOR_COUNT_EN
    ,
    output logic [7:0] RESET_EVENTS
`endif
);

    localparam int PW = $clog2(MIN_PULSE + 1);
    localparam int SW = $clog2(STRETCH + 1);
    localparam int HW = $clog2(HALT_MIN + 1);
    localparam logic [PW-1:0] PULSE_MAX    = PW'(MIN_PULSE);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH);
    localparam logic [HW-1:0] HALT_MAX     = HW'(HALT_MIN);
    localparam logic [HW-1:0] HALT_LAST    = HW'(HALT_MIN - 1);

    logic          w_rst_s;
    logic          w_halt_s;
    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_pulse_cnt;
    logic [PW-1:0] w_pulse_cnt_next;
    logic [SW-1:0] r_stretch_cnt;
    logic [HW-1:0] r_halt_cnt;
    logic          r_periph_reset;
    logic          r_reset_seen;
    logic          w_pulse_sat;
    logic          w_stretch_done;
    logic          w_qualified;

    line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
        .MCLK_IN      (MCLK_IN),
        .RESET_ALL_IN (RESET_ALL_IN),
        .i_d          (~CPU_RESET_N_IN),
        .o_q          (w_rst_s)
    );

    line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_halt (
        .MCLK_IN      (MCLK_IN),
        .RESET_ALL_IN (RESET_ALL_IN),
        .i_d          (~CPU_HALT_N_IN),
        .o_q          (w_halt_s)
    );

    assign w_pulse_sat    = (r_pulse_cnt == PULSE_MAX);
    assign w_stretch_done = (r_stretch_cnt <= SW'(1));
    assign w_qualified    = (r_state == ST_MEASURE) && (w_next_state == ST_STRETCH);

    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            r_state <= ST_WAIT_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        if (!RUN_IN) begin
            w_next_state = ST_WAIT_RUN;
        end else begin
            case (r_state)
                ST_WAIT_RUN: if (!w_rst_s && !w_halt_s) w_next_state = ST_IDLE;
                ST_IDLE: begin
                    if (w_rst_s)                                w_next_state = ST_MEASURE;
                    else if (w_halt_s && r_halt_cnt == HALT_LAST) w_next_state = ST_HALTED;
                end
                ST_MEASURE: if (!w_rst_s) w_next_state = w_pulse_sat ? ST_STRETCH : ST_IDLE;
                ST_STRETCH: begin
                    if (w_rst_s)             w_next_state = ST_MEASURE;
                    else if (w_stretch_done) w_next_state = ST_IDLE;
                end
                ST_HALTED: begin
                    if (w_rst_s)        w_next_state = ST_MEASURE;
                    else if (!w_halt_s) w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_WAIT_RUN;
            endcase
        end
    end

    // Every entry into MEASURE restarts the count at 1, including re-triggers from STRETCH and HALTED.
    always_comb begin
        w_pulse_cnt_next = '0;
        if (w_next_state == ST_MEASURE) begin
            if (r_state != ST_MEASURE) w_pulse_cnt_next = PW'(1);
            else if (w_pulse_sat)      w_pulse_cnt_next = r_pulse_cnt;
            else                       w_pulse_cnt_next = r_pulse_cnt + PW'(1);
        end
    end

    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            r_pulse_cnt    <= '0;
            r_stretch_cnt  <= '0;
            r_halt_cnt     <= '0;
            r_periph_reset <= 1'b0;
            r_reset_seen   <= 1'b0;
        end else begin
            r_pulse_cnt  <= w_pulse_cnt_next;
            r_reset_seen <= w_qualified;

            if (w_qualified)                     r_stretch_cnt <= STRETCH_LOAD;
            else if (w_next_state == ST_STRETCH) r_stretch_cnt <= r_stretch_cnt - SW'(1);
            else                                 r_stretch_cnt <= '0;

            if (r_state == ST_IDLE && w_next_state == ST_IDLE && w_halt_s) begin
                if (r_halt_cnt != HALT_MAX) r_halt_cnt <= r_halt_cnt + HW'(1);
            end else begin
                r_halt_cnt <= '0;
            end

            // A re-trigger from STRETCH keeps the peripheral reset asserted across MEASURE.
            case (w_next_state)
                ST_STRETCH: r_periph_reset <= 1'b1;
                ST_MEASURE: r_periph_reset <= r_periph_reset | (w_pulse_cnt_next == PULSE_MAX);
                default:    r_periph_reset <= 1'b0;
            endcase
        end
    end

    always_comb begin
        PERIPH_RESET = r_periph_reset;
        RESET_SEEN   = r_reset_seen;
        CPU_HALTED   = (r_state == ST_HALTED);
    end

`ifdef CPU_RESET_MONITOR_COUNT_EN
    logic [7:0] r_reset_events;

    // Survives RUN_IN drops; only RESET_ALL_IN clears it.
    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            r_reset_events <= 8'd0;
        end else if (w_qualified && r_reset_events != 8'hFF) begin
            r_reset_events <= r_reset_events + 8'd1;
        end
    end

    assign RESET_EVENTS = r_reset_events;
`endif

endmodule

// File: tb/tb_cpu_reset_monitor.sv
// Self-checking bench for cpu_reset_monitor: directed scenarios plus random pulse/halt lengths
// checked cycle by cycle against timing derived from pulse lengths.
module tb_cpu_reset_monitor;
    import pixy_reset_pkg::*;

    localparam int SYNC        = 2;
    localparam int MIN_PULSE   = 16;
    localparam int STRETCH_CYC = 64;
    localparam int HALT_MIN    = 256;

    logic mclk    = 1'b0;
    logic rst_all = 1'b0;
    logic run     = 1'b0;
    logic reset_n = 1'b1;
    logic halt_n  = 1'b1;
    logic periph;
    logic seen;
    logic halted;
`ifdef CPU_RESET_MONITOR_COUNT_EN
    logic [7:0] events;
`endif

    int n_checks   = 0;
    int n_pass     = 0;
    int exp_events = 0;

    cpu_reset_monitor #(
        .SYNC_STAGES (SYNC),
        .MIN_PULSE   (MIN_PULSE),
        .STRETCH     (STRETCH_CYC),
        .HALT_MIN    (HALT_MIN)
    ) dut (
        .MCLK_IN        (mclk),
        .RESET_ALL_IN   (rst_all),
        .RUN_IN         (run),
        .CPU_RESET_N_IN (reset_n),
        .CPU_HALT_N_IN  (halt_n),
        .PERIPH_RESET   (periph),
        .RESET_SEEN     (seen),
        .CPU_HALTED     (halted)
`ifdef CPU_RESET_MONITOR_COUNT_EN
        ,
        .RESET_EVENTS   (events)
`endif
    );

    always #5 mclk = ~mclk;

    // Advance one clock and land 1 time unit after the edge, away from it.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // RESET pin low for len samples starting at edge 1 (RUN high, FSM idle).
    // Qualified pulses: periph high over [SYNC+MIN_PULSE, len+SYNC+1+STRETCH), seen at len+SYNC+1.
    task automatic pulse_scenario(input string name, input int len);
        bit   qual;
        int   rise;
        int   seen_at;
        int   fall;
        int   seen_cnt;
        logic exp_p;
        logic exp_s;
        qual     = (len >= MIN_PULSE);
        rise     = SYNC + MIN_PULSE;
        seen_at  = len + SYNC + 1;
        fall     = seen_at + STRETCH_CYC;
        seen_cnt = 0;
        reset_n  = 1'b0;
        for (int t = 1; t <= fall + 4; t++) begin
            tick();
            if (t == len) reset_n = 1'b1;
            exp_p = qual && (t >= rise) && (t < fall);
            exp_s = qual && (t == seen_at);
            n_checks++;
            if (periph !== exp_p || seen !== exp_s || halted !== 1'b0)
                $display("FAIL %s len=%0d t=%0d periph/seen/halted=%b%b%b expected %b%b0",
                         name, len, t, periph, seen, halted, exp_p, exp_s);
            else
                n_pass++;
            if (seen === 1'b1) seen_cnt++;
        end
        n_checks++;
        if (seen_cnt !== (qual ? 1 : 0))
            $display("FAIL %s_seen_count len=%0d got %0d expected %0d", name, len, seen_cnt, qual ? 1 : 0);
        else
            n_pass++;
        if (qual) exp_events++;
`ifdef CPU_RESET_MONITOR_COUNT_EN
        n_checks++;
        if (events !== 8'(exp_events))
            $display("FAIL %s_events got %0d expected %0d", name, events, exp_events);
        else
            n_pass++;
`endif
    endtask

    task automatic test_reset();
        rst_all = 1'b0;
        #1 rst_all = 1'b1;
        #2;
        n_checks++;
        if (periph !== 1'b0 || seen !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_outputs got %b%b%b expected 000", periph, seen, halted);
        else
            n_pass++;
`ifdef CPU_RESET_MONITOR_COUNT_EN
        n_checks++;
        if (events !== 8'd0) $display("FAIL reset_events got %0d expected 0", events);
        else n_pass++;
`endif
        tick();
        tick();
        n_checks++;
        if (dut.r_state !== ST_WAIT_RUN) $display("FAIL reset_state got %0d expected WAIT_RUN", dut.r_state);
        else n_pass++;
        rst_all = 1'b0;
        run     = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (dut.r_state !== ST_IDLE || periph !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_to_idle state=%0d periph=%b halted=%b expected IDLE,0,0", dut.r_state, periph, halted);
        else
            n_pass++;
    endtask

    task automatic test_normal_reset();
        pulse_scenario("normal", 124);
    endtask

    task automatic test_glitch();
        pulse_scenario("glitch", 10);
        n_checks++;
        if (dut.r_state !== ST_IDLE) $display("FAIL glitch_state got %0d expected IDLE", dut.r_state);
        else n_pass++;
    endtask

    task automatic test_pulse_boundary();
        pulse_scenario("len_below_min", MIN_PULSE - 1);
        pulse_scenario("len_at_min", MIN_PULSE);
    endtask

    task automatic test_random_pulses();
        for (int i = 0; i < 6; i++) pulse_scenario("random", int'($urandom_range(1, 60)));
    endtask

    // HALT pin low for len samples; halted over [SYNC+HALT_MIN, len+SYNC+1) when len >= HALT_MIN.
    task automatic test_halt(input int len);
        logic exp_h;
        halt_n = 1'b0;
        for (int t = 1; t <= len + 6; t++) begin
            tick();
            if (t == len) halt_n = 1'b1;
            exp_h = (len >= HALT_MIN) && (t >= SYNC + HALT_MIN) && (t < len + SYNC + 1);
            n_checks++;
            if (halted !== exp_h || periph !== 1'b0 || seen !== 1'b0)
                $display("FAIL halt len=%0d t=%0d halted/periph/seen=%b%b%b expected %b00",
                         len, t, halted, periph, seen, exp_h);
            else
                n_pass++;
        end
    endtask

    // Second 124-cycle RESET begins 20 cycles into STRETCH: periph never drops, two RESET_SEEN pulses.
    task automatic test_back_to_back();
        int   seen_cnt;
        logic exp_p;
        logic exp_s;
        seen_cnt = 0;
        reset_n  = 1'b0;
        for (int t = 1; t <= 342; t++) begin
            tick();
            if (t == 124) reset_n = 1'b1;
            if (t == 147) reset_n = 1'b0;
            if (t == 271) reset_n = 1'b1;
            exp_p = (t >= 18) && (t < 338);
            exp_s = (t == 127) || (t == 274);
            n_checks++;
            if (periph !== exp_p || seen !== exp_s)
                $display("FAIL back_to_back t=%0d periph/seen=%b%b expected %b%b", t, periph, seen, exp_p, exp_s);
            else
                n_pass++;
            if (seen === 1'b1) seen_cnt++;
        end
        n_checks++;
        if (seen_cnt !== 2) $display("FAIL back_to_back_seen_count got %0d expected 2", seen_cnt);
        else n_pass++;
        exp_events += 2;
`ifdef CPU_RESET_MONITOR_COUNT_EN
        n_checks++;
        if (events !== 8'(exp_events)) $display("FAIL back_to_back_events got %0d expected %0d", events, exp_events);
        else n_pass++;
`endif
    endtask

    task automatic test_run_gating();
        logic exp_p;
        run     = 1'b0;
        reset_n = 1'b0;
        for (int t = 1; t <= 130; t++) begin
            tick();
            if (t == 124) reset_n = 1'b1;
            n_checks++;
            if (periph !== 1'b0 || seen !== 1'b0 || halted !== 1'b0)
                $display("FAIL run_low t=%0d outputs=%b%b%b expected 000", t, periph, seen, halted);
            else
                n_pass++;
        end
        n_checks++;
        if (dut.r_state !== ST_WAIT_RUN) $display("FAIL run_low_state got %0d expected WAIT_RUN", dut.r_state);
        else n_pass++;
        run = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut.r_state !== ST_IDLE) $display("FAIL run_high_state got %0d expected IDLE", dut.r_state);
        else n_pass++;
        // 30-cycle qualified pulse; RUN_IN drops 7 cycles into STRETCH.
        reset_n = 1'b0;
        for (int t = 1; t <= 41; t++) begin
            tick();
            if (t == 30) reset_n = 1'b1;
            exp_p = (t >= 18) && (t <= 40);
            n_checks++;
            if (periph !== exp_p || seen !== (t == 33))
                $display("FAIL run_drop t=%0d periph/seen=%b%b expected %b%b", t, periph, seen, exp_p, t == 33);
            else
                n_pass++;
            if (t == 40) run = 1'b0;
        end
        n_checks++;
        if (dut.r_state !== ST_WAIT_RUN) $display("FAIL run_drop_state got %0d expected WAIT_RUN", dut.r_state);
        else n_pass++;
        exp_events++;
`ifdef CPU_RESET_MONITOR_COUNT_EN
        n_checks++;
        if (events !== 8'(exp_events)) $display("FAIL run_drop_events got %0d expected %0d", events, exp_events);
        else n_pass++;
`endif
        run = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        reset_n = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (periph !== 1'b1 || dut.r_state !== ST_MEASURE)
            $display("FAIL async_pre periph=%b state=%0d expected 1,MEASURE", periph, dut.r_state);
        else
            n_pass++;
        #2 rst_all = 1'b1;
        #1;
        n_checks++;
        if (periph !== 1'b0 || seen !== 1'b0 || halted !== 1'b0 || dut.r_state !== ST_WAIT_RUN)
            $display("FAIL async_reset outputs=%b%b%b state=%0d expected 000,WAIT_RUN", periph, seen, halted, dut.r_state);
        else
            n_pass++;
        exp_events = 0;
`ifdef CPU_RESET_MONITOR_COUNT_EN
        n_checks++;
        if (events !== 8'd0) $display("FAIL async_events got %0d expected 0", events);
        else n_pass++;
`endif
        reset_n = 1'b1;
        tick();
        tick();
        rst_all = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (dut.r_state !== ST_IDLE || periph !== 1'b0)
            $display("FAIL async_recover state=%0d periph=%b expected IDLE,0", dut.r_state, periph);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal_reset();
        test_glitch();
        test_pulse_boundary();
        test_halt(300);
        test_halt(HALT_MIN - 1);
        test_halt(HALT_MIN);
        test_halt(int'($urandom_range(100, 400)));
        test_back_to_back();
        test_random_pulses();
        test_run_gating();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
